tile_frame_buffer: RTL and testbench



---
 rtl/frame_buffer_pkg.sv | 33 +++
 rtl/axis_skid_buffer.sv | 58 +++++
 rtl/tile_frame_buffer.sv | 233 +++++++++++++++++++++++
 tb/tb_tile_frame_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared types and derived-width helpers for the tile frame buffer.
// Contents: FSM state encoding and constant functions that turn the
// top-level generics into beat, lane and address widths.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_MEMSET = 2'd2,
        ST_LOAD   = 2'd3
    } fb_state_e;

    function automatic int unsigned pixels_per_beat(input int unsigned stream_w,
                                                    input int unsigned pixel_w);
        return stream_w / pixel_w;
    endfunction

    function automatic int unsigned subpix(input int unsigned pixel_w,
                                           input int unsigned sub_w);
        return pixel_w / sub_w;
    endfunction

    function automatic int unsigned beats(input int unsigned frame_size,
                                          input int unsigned ppb);
        return frame_size / ppb;
    endfunction

    // Address width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry stream buffer. The upstream side pushes without a ready signal
// and must use o_count (plus its own in-flight requests) to never overrun.
// Ports: i_clk, i_rst_n (async, active-low), i_valid/i_data push side,
//        o_count occupancy, o_valid/i_ready/o_data stream side.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic [1:0]       o_count,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;

    // Head only changes on a pop or when empty, so data holds while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_valid, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tile_frame_buffer.sv
// One tile of pixels in block RAM with a 1-cycle fragment port, plus
// commit (AXIS master), memset (clear colour) and load (AXIS slave)
// commands under an apply/applied handshake.
// Ports: clk, resetn (async active-low); fragIndexRead/fragOut,
//        fragIndexWrite/fragIn/fragWriteEnable/fragMask fragment port;
//        apply/applied, cmdCommit/cmdMemset/cmdLoad, clearColor;
//        m_axis_* commit stream; s_axis_* load stream;
//        scissorStart/scissorEnd {y,x} only when SCISSOR_EN is defined.
// Build option: SCISSOR_EN restricts memset to a pixel rectangle.
module tile_frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter  int unsigned FRAME_SIZE      = 128*128,
    parameter  int unsigned X_RESOLUTION    = 128,
    parameter  int unsigned PIXEL_WIDTH     = 16,
    parameter  int unsigned SUB_PIXEL_WIDTH = 4,
    parameter  int unsigned STREAM_WIDTH    = 32,
    localparam int unsigned PPB             = pixels_per_beat(STREAM_WIDTH, PIXEL_WIDTH),
    localparam int unsigned SUBPIX          = subpix(PIXEL_WIDTH, SUB_PIXEL_WIDTH),
    localparam int unsigned ADDR_WIDTH      = clog2_min1(FRAME_SIZE)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   fragIndexRead,
    output logic [PIXEL_WIDTH-1:0]  fragOut,
    input  logic [ADDR_WIDTH-1:0]   fragIndexWrite,
    input  logic [PIXEL_WIDTH-1:0]  fragIn,
    input  logic                    fragWriteEnable,
    input  logic [SUBPIX-1:0]       fragMask,
    input  logic                    apply,
    output logic                    applied,
    input  logic                    cmdCommit,
    input  logic                    cmdMemset,
    input  logic                    cmdLoad,
    input  logic [PIXEL_WIDTH-1:0]  clearColor,
`ifdef SCISSOR_EN
    input  logic [31:0]             scissorStart,
    input  logic [31:0]             scissorEnd,
`endif
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [STREAM_WIDTH-1:0] m_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0] s_axis_tdata
);

    localparam int unsigned BEATS          = beats(FRAME_SIZE, PPB);
    localparam int unsigned MEM_ADDR_WIDTH = clog2_min1(BEATS);
    localparam int unsigned STRB_W         = STREAM_WIDTH / SUB_PIXEL_WIDTH;
    localparam int unsigned LANE_W         = clog2_min1(PPB);
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_BEAT = MEM_ADDR_WIDTH'(BEATS - 1);

    if ((FRAME_SIZE % PPB) != 0 || (PIXEL_WIDTH % SUB_PIXEL_WIDTH) != 0 ||
        (X_RESOLUTION % PPB) != 0) begin : g_param_check
        $error("tile_frame_buffer: illegal parameter combination");
    end

    fb_state_e                 r_state, w_next;
    logic                      r_applied, r_s_ready, r_cmd_memset;
    logic                      r_rd_valid, r_rd_last, r_rd_done;
    logic [MEM_ADDR_WIDTH-1:0] r_beat;
    logic [STREAM_WIDTH-1:0]   r_mem [BEATS];
    logic [STREAM_WIDTH-1:0]   r_rd_beat;
    logic [LANE_W-1:0]         r_frd_lane;

    logic [MEM_ADDR_WIDTH-1:0] w_frd_beat, w_fwr_beat, w_rd_addr, w_wr_addr;
    logic [LANE_W-1:0]         w_frd_lane, w_fwr_lane;
    logic                      w_we, w_issue, w_pop, w_s_acc;
    logic [STREAM_WIDTH-1:0]   w_wr_data;
    logic [STRB_W-1:0]         w_wr_strb, w_sc_strb;
    logic [1:0]                w_sk_count;
    logic                      w_sk_valid;
    logic [STREAM_WIDTH:0]     w_sk_data;

    // Pixel index -> beat address and pixel lane within the beat.
    assign w_frd_beat = MEM_ADDR_WIDTH'(fragIndexRead / ADDR_WIDTH'(PPB));
    assign w_frd_lane = LANE_W'(fragIndexRead % ADDR_WIDTH'(PPB));
    assign w_fwr_beat = MEM_ADDR_WIDTH'(fragIndexWrite / ADDR_WIDTH'(PPB));
    assign w_fwr_lane = LANE_W'(fragIndexWrite % ADDR_WIDTH'(PPB));
    assign w_rd_addr  = (r_state == ST_COMMIT) ? r_beat : w_frd_beat;

    assign applied       = r_applied;
    assign s_axis_tready = r_s_ready;
    assign fragOut       = r_rd_beat[32'(r_frd_lane) * PIXEL_WIDTH +: PIXEL_WIDTH];
    assign m_axis_tvalid = w_sk_valid;
    assign m_axis_tdata  = w_sk_data[STREAM_WIDTH-1:0];
    assign m_axis_tlast  = w_sk_data[STREAM_WIDTH] & w_sk_valid;
    assign w_pop         = w_sk_valid & m_axis_tready;

`ifdef SCISSOR_EN
    logic [15:0] r_sx, r_sy;

    // Per-pixel rectangle test for the beat currently being cleared.
    always_comb begin
        w_sc_strb = '0;
        for (int p = 0; p < int'(PPB); p++) begin
            if ((r_sx + 16'(p)) >= scissorStart[15:0] && (r_sx + 16'(p)) < scissorEnd[15:0] &&
                r_sy >= scissorStart[31:16] && r_sy < scissorEnd[31:16]) begin
                w_sc_strb[p*SUBPIX +: SUBPIX] = '1;
            end
        end
    end

    // x/y of the first pixel in the current memset beat, stepped per beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (r_state != ST_MEMSET) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (r_sx == 16'(X_RESOLUTION - PPB)) begin
            r_sx <= '0;
            r_sy <= r_sy + 16'd1;
        end else begin
            r_sx <= r_sx + 16'(PPB);
        end
    end
`else
    assign w_sc_strb = '1;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next state and RAM port steering.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_s_acc   = 1'b0;
        w_we      = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        w_wr_strb = '0;
        case (r_state)
            ST_IDLE: begin
                if (fragWriteEnable) begin
                    w_we      = 1'b1;
                    w_wr_addr = w_fwr_beat;
                    w_wr_data = {PPB{fragIn}};
                    w_wr_strb = STRB_W'(fragMask) << (32'(w_fwr_lane) * SUBPIX);
                end
                if (apply) begin
                    if (cmdCommit)      w_next = ST_COMMIT;
                    else if (cmdMemset) w_next = ST_MEMSET;
                    else if (cmdLoad)   w_next = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                // Issue only if the read lands in a slot that is free by then.
                w_issue = !r_rd_done &&
                          ((3'(w_sk_count) + 3'(r_rd_valid)) < (3'd2 + 3'(w_pop)));
                if (w_pop && w_sk_data[STREAM_WIDTH])
                    w_next = r_cmd_memset ? ST_MEMSET : ST_IDLE;
            end
            ST_MEMSET: begin
                w_we      = 1'b1;
                w_wr_addr = r_beat;
                w_wr_data = {PPB{clearColor}};
                w_wr_strb = {PPB{fragMask}} & w_sc_strb;
                if (r_beat == LAST_BEAT) w_next = ST_IDLE;
            end
            ST_LOAD: begin
                w_s_acc   = s_axis_tvalid & r_s_ready;
                w_we      = w_s_acc;
                w_wr_addr = r_beat;
                w_wr_data = s_axis_tdata;
                w_wr_strb = '1;
                if (w_s_acc && (s_axis_tlast || r_beat == LAST_BEAT)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Control registers: handshake, beat counter, read pipeline tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_applied    <= 1'b1;
            r_s_ready    <= 1'b0;
            r_cmd_memset <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_done    <= 1'b0;
            r_beat       <= '0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) r_rd_last <= (r_beat == LAST_BEAT);
            r_s_ready  <= (w_next == ST_LOAD);
            r_applied  <= (w_next == ST_IDLE);
            if (r_state == ST_IDLE && apply) r_cmd_memset <= cmdMemset;
            if (w_next != r_state) begin
                r_beat    <= '0;
                r_rd_done <= 1'b0;
            end else if (w_issue || r_state == ST_MEMSET || w_s_acc) begin
                if (r_beat == LAST_BEAT) r_rd_done <= 1'b1;
                else                     r_beat    <= r_beat + 1'b1;
            end
        end
    end

    // Tile RAM: one sub-pixel-strobed write port, one registered read port.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int k = 0; k < int'(STRB_W); k++) begin
                if (w_wr_strb[k])
                    r_mem[w_wr_addr][k*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH] <=
                        w_wr_data[k*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH];
            end
        end
        r_rd_beat  <= r_mem[w_rd_addr];
        r_frd_lane <= w_frd_lane;
    end

    axis_skid_buffer #(
        .WIDTH (STREAM_WIDTH + 1)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_valid (r_rd_valid),
        .i_data  ({r_rd_last, r_rd_beat}),
        .o_count (w_sk_count),
        .o_valid (w_sk_valid),
        .i_ready (m_axis_tready),
        .o_data  (w_sk_data)
    );

endmodule

// File: tb/tb_tile_frame_buffer.sv
// Self-checking bench for tile_frame_buffer (64-pixel tile, 32-bit stream).
// A pixel-level array is the reference; streams are compared beat by beat.
module tb_tile_frame_buffer;

    localparam int unsigned FS = 64, XR = 8, PW = 16, SPW = 4, SW = 32;
    localparam int BEATS = 32;

    logic          clk, resetn;
    logic [5:0]    fragIndexRead, fragIndexWrite;
    logic [15:0]   fragOut, fragIn, clearColor;
    logic          fragWriteEnable, apply, applied;
    logic [3:0]    fragMask;
    logic          cmdCommit, cmdMemset, cmdLoad;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0]   m_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [31:0]   s_axis_tdata;
`ifdef SCISSOR_EN
    logic [31:0]   sc_start, sc_end;
`endif

    tile_frame_buffer #(
        .FRAME_SIZE(FS), .X_RESOLUTION(XR), .PIXEL_WIDTH(PW),
        .SUB_PIXEL_WIDTH(SPW), .STREAM_WIDTH(SW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .fragIndexRead(fragIndexRead), .fragOut(fragOut),
        .fragIndexWrite(fragIndexWrite), .fragIn(fragIn),
        .fragWriteEnable(fragWriteEnable), .fragMask(fragMask),
        .apply(apply), .applied(applied),
        .cmdCommit(cmdCommit), .cmdMemset(cmdMemset), .cmdLoad(cmdLoad),
        .clearColor(clearColor),
`ifdef SCISSOR_EN
        .scissorStart(sc_start), .scissorEnd(sc_end),
`endif
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] model [64];
    logic [31:0] last_stream [32];

    typedef struct {
        int          wr_idx;
        logic [15:0] wr_data;
        logic [3:0]  mask;
        int          rd_idx;
        logic [15:0] exp;
    } vec_t;
    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rect(input int idx);
`ifdef SCISSOR_EN
        int x, y;
        x = idx % XR;
        y = idx / XR;
        return x >= int'(sc_start[15:0]) && x < int'(sc_end[15:0]) &&
               y >= int'(sc_start[31:16]) && y < int'(sc_end[31:16]);
`else
        return idx >= 0;
`endif
    endfunction

    task automatic model_write(input int idx, input logic [15:0] d, input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[k]) model[idx][4*k +: 4] = d[4*k +: 4];
    endtask

    task automatic frag_write(input int idx, input logic [15:0] d, input logic [3:0] m);
        fragIndexWrite = 6'(idx); fragIn = d; fragMask = m; fragWriteEnable = 1'b1;
        tick();
        fragWriteEnable = 1'b0;
        model_write(idx, d, m);
    endtask

    task automatic frag_read(input int idx, output logic [15:0] d);
        fragIndexRead = 6'(idx);
        tick();
        d = fragOut;
    endtask

    task automatic start_cmd(input logic c, input logic m, input logic l);
        cmdCommit = c; cmdMemset = m; cmdLoad = l; apply = 1'b1;
        tick();
        apply = 1'b0; cmdCommit = 1'b0; cmdMemset = 1'b0; cmdLoad = 1'b0;
    endtask

    // mode 0: tready=1, 1: 1010 with a 10-cycle stall, 2: random
    task automatic run_commit(input int mode, input bit junk);
        int got = 0, cyc = 0;
        logic pv = 1'b0, pr = 1'b0;
        logic [31:0] pd = '0;
        while (got < BEATS && cyc < 2000) begin
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (cyc >= 20 && cyc < 30) ? 1'b0 : (cyc % 2 == 0);
                default: m_axis_tready = 1'($urandom);
            endcase
            fragWriteEnable = junk;
            fragIndexWrite = 6'($urandom); fragIn = 16'($urandom); fragMask = 4'hF;
            if (pv && !pr) begin
                check("tvalid_hold", m_axis_tvalid, 1);
                check("tdata_hold", m_axis_tdata, pd);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("commit_beat", m_axis_tdata, {model[2*got+1], model[2*got]});
                check("commit_tlast", m_axis_tlast, got == BEATS - 1);
                last_stream[got] = m_axis_tdata;
                got++;
            end
            pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata;
            tick();
            cyc++;
        end
        fragWriteEnable = 1'b0;
        m_axis_tready = 1'b0;
        if (got < BEATS) check("commit_timeout", got, BEATS);
    endtask

    task automatic wait_memset(input logic [15:0] color, input logic [3:0] m);
        int n = 0;
        while (!applied && n < 100) begin
            n++;
            tick();
        end
        check("memset_cycles", n, 32);
        for (int i = 0; i < 64; i++)
            if (in_rect(i)) model_write(i, color, m);
    endtask

    task automatic run_load(input int tlast_at, input bit rnd, input int exp_n);
        int k = 0, cyc = 0;
        while (!applied && cyc < 500) begin
            s_axis_tvalid = rnd ? 1'($urandom) : 1'b1;
            s_axis_tdata  = $urandom;
            s_axis_tlast  = (k == tlast_at) || (k >= BEATS);
            if (s_axis_tvalid && s_axis_tready) begin
                if (k >= BEATS) begin
                    check("load_overrun", k, BEATS - 1);
                    break;
                end
                model[2*k]   = s_axis_tdata[15:0];
                model[2*k+1] = s_axis_tdata[31:16];
                k++;
            end
            tick();
            cyc++;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("load_beats", k, exp_n);
        check("load_applied", applied, 1);
        check("load_tready_low", s_axis_tready, 0);
    endtask

    initial begin
        logic [15:0] rd;
        int got;

        vt[0] = '{5,  16'hABCD, 4'hF, 5,  16'hABCD};
        vt[1] = '{6,  16'h1234, 4'hF, 6,  16'h1234};
        vt[2] = '{9,  16'hFFFF, 4'h1, 9,  16'h000F};
        vt[3] = '{9,  16'h1234, 4'h8, 9,  16'h100F};
        vt[4] = '{63, 16'hBEEF, 4'hF, 63, 16'hBEEF};
        vt[5] = '{0,  16'h5A5A, 4'h6, 0,  16'h0A50};
        vt[6] = '{7,  16'hFFFF, 4'h0, 7,  16'h0000};
        vt[7] = '{62, 16'hC3C3, 4'hF, 63, 16'hBEEF};

        resetn = 1'b0; apply = 1'b0; cmdCommit = 1'b0; cmdMemset = 1'b0; cmdLoad = 1'b0;
        fragIndexRead = '0; fragIndexWrite = '0; fragIn = '0; fragMask = '0;
        fragWriteEnable = 1'b0; clearColor = '0; m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
`ifdef SCISSOR_EN
        sc_start = 32'h0; sc_end = {16'd8, 16'd8};
`endif
        #12;
        check("rst_applied", applied, 1);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_s_tready", s_axis_tready, 0);
        resetn = 1'b1;
        tick();

        // Known tile contents: clear everything to zero.
        clearColor = 16'h0000; fragMask = 4'hF;
        start_cmd(0, 1, 0);
        check("memset_applied_low", applied, 0);
        wait_memset(16'h0000, 4'hF);

        for (int i = 0; i < 8; i++) begin
            frag_write(vt[i].wr_idx, vt[i].wr_data, vt[i].mask);
            frag_read(vt[i].rd_idx, rd);
            check($sformatf("frag_vec%0d", i), rd, vt[i].exp);
        end

        start_cmd(1, 0, 0);
        run_commit(1, 1'b0);
        check("commit_applied", applied, 1);
        check("commit_no_extra", m_axis_tvalid, 0);
        check("beat2_upper", last_stream[2][31:16], 16'hABCD);

        start_cmd(0, 0, 0);
        check("nocmd_applied", applied, 1);

        clearColor = 16'h1234; fragMask = 4'hF;
        start_cmd(1, 1, 0);
        run_commit(2, 1'b0);
        wait_memset(16'h1234, 4'hF);
        start_cmd(1, 0, 0);
        run_commit(0, 1'b0);
        check("memset_beat0", last_stream[0], 32'h12341234);

        start_cmd(0, 0, 1);
        run_load(10, 1'b1, 11);
        start_cmd(1, 0, 0);
        run_commit(2, 1'b0);
        check("load_beat11_kept", last_stream[11], 32'h12341234);

        start_cmd(0, 0, 1);
        run_load(-1, 1'b1, 32);
        start_cmd(1, 0, 0);
        run_commit(0, 1'b0);

        // Reset in the middle of a commit.
        start_cmd(1, 0, 0);
        got = 0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 100 && got < 7; c++) begin
            if (m_axis_tvalid) got++;
            tick();
        end
        #3 resetn = 1'b0;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_applied", applied, 1);
        m_axis_tready = 1'b0;
        tick();
        #3 resetn = 1'b1;
        tick();
        start_cmd(1, 0, 0);
        run_commit(2, 1'b0);

        // Randomised fragment traffic, masked memsets and commits.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++)
                frag_write(int'($urandom_range(63)), 16'($urandom), 4'($urandom));
            for (int i = 0; i < 6; i++) begin
                int idx;
                idx = int'($urandom_range(63));
                frag_read(idx, rd);
                check("rand_read", rd, model[idx]);
            end
            start_cmd(1, 0, 0);
            run_commit(2, 1'b1);
            clearColor = 16'($urandom); fragMask = 4'($urandom);
            start_cmd(0, 1, 0);
            wait_memset(clearColor, fragMask);
            start_cmd(1, 0, 0);
            run_commit(2, 1'b0);
        end

`ifdef SCISSOR_EN
        clearColor = 16'hFFFF; fragMask = 4'hF;
        start_cmd(0, 1, 0);
        wait_memset(16'hFFFF, 4'hF);
        sc_start = {16'd2, 16'd2}; sc_end = {16'd4, 16'd4};
        clearColor = 16'h0000;
        start_cmd(0, 1, 0);
        wait_memset(16'h0000, 4'hF);
        for (int i = 0; i < 64; i++) begin
            frag_read(i, rd);
            check("scissor_px", rd,
                  (i == 18 || i == 19 || i == 26 || i == 27) ? 16'h0000 : 16'hFFFF);
        end
        sc_start = 32'h0; sc_end = {16'd8, 16'd8};
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
